// File: rtl/fperm_sched_pkg.sv
// rtl/fperm_sched_pkg.sv - op encoding, widths and control decode for the permute scheduler
package fperm_sched_pkg;

    localparam int TAG_W  = 9;
    localparam int OPND_W = 68;

    typedef enum logic [2:0] {
        PERM_COPY_B  = 3'd0,
        PERM_COPY_A  = 3'd1,
        PERM_SWAP_B  = 3'd2,
        PERM_SWAP_A  = 3'd3,
        PERM_FORK_LO = 3'd4,
        PERM_FORK_HI = 3'd5
    } perm_op_e;

    typedef struct packed {
        logic legal;
        logic copy_a;
        logic swp;
        logic fork_en;
    } perm_ctl_t;

    function automatic perm_ctl_t perm_decode(input logic [2:0] op);
        perm_ctl_t c;
        c = '0;
        case (op)
            PERM_COPY_B: begin
                c.legal = 1'b1;
            end
            PERM_COPY_A: begin
                c.legal  = 1'b1;
                c.copy_a = 1'b1;
            end
            PERM_SWAP_B: begin
                c.legal = 1'b1;
                c.swp   = 1'b1;
            end
            PERM_SWAP_A: begin
                c.legal  = 1'b1;
                c.copy_a = 1'b1;
                c.swp    = 1'b1;
            end
            PERM_FORK_LO: begin
                c.legal   = 1'b1;
                c.copy_a  = 1'b1;
                c.fork_en = 1'b1;
            end
            PERM_FORK_HI: begin
                c.legal   = 1'b1;
                c.fork_en = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fperm_sched_rr_arb.sv
// rtl/fperm_sched_rr_arb.sv - round-robin arbiter, search starts after the last granted port
module rr_arb #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] last;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && ((int'(last) + 1 + k) % NREQ) == i) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    // Reset parks the pointer on the highest port so port 0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= PW'(NREQ - 1);
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) last <= PW'(i);
            end
        end
    end

endmodule

// File: rtl/fperm_sched.sv
// rtl/fperm_sched.sv - shares one permute unit among NREQ issue ports and tracks its writeback
module fperm_sched import fperm_sched_pkg::*; #(
    parameter int LAT  = 1,
    parameter int NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ*4-1:0]     req_op,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    output logic [NREQ-1:0]       req_rdy,
    input  logic                  wb_claim,
    input  logic                  flush,
    output logic                  pm_en,
    output logic                  pm_copyA,
    output logic                  pm_swpSngl,
    output logic                  pm_dupSngl,
    output logic                  pm_fork,
    output logic                  res_vld,
    output logic [TAG_W-1:0]      res_tag,
    output logic                  bad_op
);

    logic              blk;
    logic [NREQ-1:0]   gnt;
    logic              any_gnt;
    logic              go;
    logic [3:0]        g_op;
    logic [TAG_W-1:0]  g_tag;
    perm_ctl_t         ctl;

    logic [LAT-1:0]    pv;
    logic [TAG_W-1:0]  pt [LAT];

    // A claimed writeback slot, a flush or reset all hold off every port.
    assign blk = wb_claim | flush | ~rst;

    rr_arb #(.NREQ(NREQ)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_vld & {NREQ{~blk}}),
        .gnt (gnt)
    );

    assign req_rdy = gnt;
    assign any_gnt = |gnt;

    always_comb begin
        g_op  = '0;
        g_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g_op  = g_op  | req_op[i*4 +: 4];
                g_tag = g_tag | req_tag[i*TAG_W +: TAG_W];
            end
        end
        ctl = perm_decode(g_op[2:0]);
    end

    assign go = any_gnt & ctl.legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pm_en      <= 1'b0;
            pm_copyA   <= 1'b0;
            pm_swpSngl <= 1'b0;
            pm_dupSngl <= 1'b0;
            pm_fork    <= 1'b0;
            bad_op     <= 1'b0;
        end else begin
            pm_en  <= go;
            bad_op <= any_gnt & ~ctl.legal;
            if (go) begin
                pm_copyA   <= ctl.copy_a;
                pm_swpSngl <= ctl.swp;
                pm_dupSngl <= g_op[3];
                pm_fork    <= ctl.fork_en;
            end
        end
    end

    // Tag/valid delay line; the output register supplies the final cycle of latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
            for (int s = 0; s < LAT; s++) pt[s] <= '0;
        end else begin
            pv[0] <= go & ~flush;
            pt[0] <= g_tag;
            for (int s = 1; s < LAT; s++) begin
                pv[s] <= pv[s-1] & ~flush;
                pt[s] <= pt[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_vld <= 1'b0;
            res_tag <= '0;
        end else begin
            res_vld <= pv[LAT-1] & ~flush;
            if (pv[LAT-1]) res_tag <= pt[LAT-1];
        end
    end

endmodule
